// File: rtl/instr_queue.sv
// Instruction queue between fetch and decode: compacts up to 8 masked lanes per cycle
// into a circular buffer and drains one entry per cycle. Optional perf counters: IQ_PERF_CNT_EN.
module instr_queue #(
  parameter int DEPTH = 32,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iq_enqueue_i,
  input  logic [7:0]       inst_mask_i,
  input  logic [7:0][31:0] enq_pc_i,
  input  logic [7:0][31:0] enq_ir_i,
  input  logic [7:0][1:0]  enq_br_pred_i,
  input  logic             iq_flush_i,
  output logic             if_stall_o,
  output logic             deq_valid_o,
  input  logic             deq_ready_i,
  output logic [31:0]      deq_pc_o,
  output logic [31:0]      deq_ir_o,
  output logic [1:0]       deq_br_pred_o,
`ifdef IQ_PERF_CNT_EN
  output logic [31:0]      perf_stall_cycles_o,
  output logic [31:0]      perf_empty_cycles_o,
`endif
  output logic [PTR_W:0]   count_o
);

  localparam int LANES = 8;
  localparam logic [PTR_W:0] STALL_TH = (PTR_W+1)'(DEPTH - LANES);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [1:0]  br;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           head_entry;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;
  logic [PTR_W-1:0] wr_addr [LANES];
  logic [3:0]       enq_n;
  logic             enq_fire;
  logic             deq_fire;

  // Each set lane lands at tail plus the number of set lanes below it.
  always_comb begin
    enq_n = '0;
    for (int i = 0; i < LANES; i++) begin
      wr_addr[i] = tail + PTR_W'(enq_n);
      enq_n      = enq_n + {3'b000, inst_mask_i[i]};
    end
  end

  assign if_stall_o  = (count > STALL_TH);
  assign deq_valid_o = (count != '0);
  assign enq_fire    = iq_enqueue_i & ~if_stall_o & ~iq_flush_i;
  assign deq_fire    = deq_valid_o & deq_ready_i & ~iq_flush_i;
  assign count_o     = count;

  always_ff @(posedge clk) begin
    if (enq_fire) begin
      for (int i = 0; i < LANES; i++) begin
        if (inst_mask_i[i]) begin
          mem[wr_addr[i]] <= '{pc: enq_pc_i[i], ir: enq_ir_i[i], br: enq_br_pred_i[i]};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || iq_flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq_fire) tail <= tail + PTR_W'(enq_n);
      if (deq_fire) head <= head + PTR_W'(1);
      count <= count + (enq_fire ? (PTR_W+1)'(enq_n) : '0) - (PTR_W+1)'(deq_fire);
    end
  end

  // Storage is never cleared, so outputs are masked to zero while empty.
  assign head_entry    = mem[head];
  assign deq_pc_o      = deq_valid_o ? head_entry.pc : '0;
  assign deq_ir_o      = deq_valid_o ? head_entry.ir : '0;
  assign deq_br_pred_o = deq_valid_o ? head_entry.br : '0;

`ifdef IQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles_o <= '0;
      perf_empty_cycles_o <= '0;
    end else begin
      if (if_stall_o && (perf_stall_cycles_o != 32'hFFFF_FFFF))
        perf_stall_cycles_o <= perf_stall_cycles_o + 32'd1;
      if (!deq_valid_o && (perf_empty_cycles_o != 32'hFFFF_FFFF))
        perf_empty_cycles_o <= perf_empty_cycles_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue: compaction, gaps, stall threshold, wrap, flush, reset.
module tb_instr_queue;
  logic             clk;
  logic             rst;
  logic             iq_enqueue_i;
  logic [7:0]       inst_mask_i;
  logic [7:0][31:0] enq_pc_i;
  logic [7:0][31:0] enq_ir_i;
  logic [7:0][1:0]  enq_br_pred_i;
  logic             iq_flush_i;
  logic             if_stall_o;
  logic             deq_valid_o;
  logic             deq_ready_i;
  logic [31:0]      deq_pc_o;
  logic [31:0]      deq_ir_o;
  logic [1:0]       deq_br_pred_o;
  logic [5:0]       count_o;
`ifdef IQ_PERF_CNT_EN
  logic [31:0]      perf_stall_cycles_o;
  logic [31:0]      perf_empty_cycles_o;
`endif

  int errors = 0;
  int checks = 0;
  int gap_ir[4] = '{0, 2, 5, 7};

  instr_queue #(.DEPTH(32)) dut (
    .clk(clk), .rst(rst),
    .iq_enqueue_i(iq_enqueue_i), .inst_mask_i(inst_mask_i),
    .enq_pc_i(enq_pc_i), .enq_ir_i(enq_ir_i), .enq_br_pred_i(enq_br_pred_i),
    .iq_flush_i(iq_flush_i), .if_stall_o(if_stall_o),
    .deq_valid_o(deq_valid_o), .deq_ready_i(deq_ready_i),
    .deq_pc_o(deq_pc_o), .deq_ir_o(deq_ir_o), .deq_br_pred_o(deq_br_pred_o),
`ifdef IQ_PERF_CNT_EN
    .perf_stall_cycles_o(perf_stall_cycles_o),
    .perf_empty_cycles_o(perf_empty_cycles_o),
`endif
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_lanes(input logic [31:0] pc_base, input logic [31:0] ir_base);
    for (int i = 0; i < 8; i++) begin
      enq_pc_i[i]      = pc_base + 32'(4 * i);
      enq_ir_i[i]      = ir_base + 32'(i);
      enq_br_pred_i[i] = 2'(i);
    end
  endtask

  initial begin
    clk = 0; rst = 1;
    iq_enqueue_i = 0; inst_mask_i = 8'h00; iq_flush_i = 0; deq_ready_i = 0;
    set_lanes(32'h0, 32'h0);
    step(); step();
    chk("reset_count", count_o, 0);
    chk("reset_valid", deq_valid_o, 0);
    chk("reset_stall", if_stall_o, 0);
    chk("reset_pc", deq_pc_o, 0);
    chk("reset_ir", deq_ir_o, 0);
    chk("reset_br", deq_br_pred_o, 0);
    rst = 0;
`ifdef IQ_PERF_CNT_EN
    chk("perf_reset_empty", perf_empty_cycles_o, 0);
    step(); step(); step();
    chk("perf_empty_3", perf_empty_cycles_o, 3);
    chk("perf_stall_0", perf_stall_cycles_o, 0);
`endif

    // Mask/compaction: lanes 2..7
    set_lanes(32'haaaaa000, 32'h100);
    inst_mask_i = 8'b11111100; iq_enqueue_i = 1; deq_ready_i = 1;
    chk("no_bypass_valid", deq_valid_o, 0);
    step();
    iq_enqueue_i = 0;
    chk("compact_count", count_o, 6);
    chk("compact_br", deq_br_pred_o, 2);
    chk("compact_ir", deq_ir_o, 32'h102);
    for (int k = 0; k < 6; k++) begin
      chk("compact_pc", deq_pc_o, 32'haaaaa008 + 32'(4 * k));
      step();
    end
    chk("compact_empty_valid", deq_valid_o, 0);
    chk("compact_empty_count", count_o, 0);

    // Compaction with gaps
    deq_ready_i = 0;
    for (int i = 0; i < 8; i++) enq_ir_i[i] = 32'(i);
    inst_mask_i = 8'b10100101; iq_enqueue_i = 1;
    step();
    iq_enqueue_i = 0;
    deq_ready_i = 1;
    for (int k = 0; k < 4; k++) begin
      chk("gap_ir", deq_ir_o, 32'(gap_ir[k]));
      chk("gap_count", count_o, 4 - k);
      step();
    end
    chk("gap_final_count", count_o, 0);
    deq_ready_i = 0;

    // Stall threshold
    inst_mask_i = 8'hFF;
    for (int b = 0; b < 3; b++) begin
      set_lanes(32'h1000 + 32'(32 * b), 32'h0);
      iq_enqueue_i = 1;
      step();
    end
    chk("stall_count24", count_o, 24);
    chk("stall_at24", if_stall_o, 0);
    set_lanes(32'h1060, 32'h0);
    step();
    chk("stall_count32", count_o, 32);
    chk("stall_at32", if_stall_o, 1);
    set_lanes(32'hdead0000, 32'h0);
    step();
    iq_enqueue_i = 0;
    chk("stall_ignored_count", count_o, 32);
    deq_ready_i = 1;
    for (int k = 0; k < 8; k++) begin
      chk("stall_drain_pc", deq_pc_o, 32'h1000 + 32'(4 * k));
      if (k == 7) chk("stall_at25", if_stall_o, 1);
      step();
    end
    chk("stall_released_count", count_o, 24);
    chk("stall_released", if_stall_o, 0);
    chk("stall_next_pc", deq_pc_o, 32'h1020);
    repeat (24) step();
    deq_ready_i = 0;
    chk("stall_drained", count_o, 0);

    // Wrap-around: move head and tail to 28 (currently at 10)
    set_lanes(32'h9000, 32'h0);
    iq_enqueue_i = 1; inst_mask_i = 8'hFF;
    step(); step();
    inst_mask_i = 8'h03;
    step();
    iq_enqueue_i = 0;
    chk("wrap_pre_count", count_o, 18);
    deq_ready_i = 1;
    repeat (18) step();
    deq_ready_i = 0;
    chk("wrap_pre_empty", count_o, 0);
    set_lanes(32'h2000, 32'h0);
    inst_mask_i = 8'hFF; iq_enqueue_i = 1;
    step();
    chk("wrap_count", count_o, 8);
    set_lanes(32'h3000, 32'h0);
    inst_mask_i = 8'h01; deq_ready_i = 1;
    chk("wrap_pc0", deq_pc_o, 32'h2000);
    step();
    iq_enqueue_i = 0;
    chk("enq_deq_same_cycle_count", count_o, 8);
    for (int k = 1; k < 8; k++) begin
      chk("wrap_pc", deq_pc_o, 32'h2000 + 32'(4 * k));
      step();
    end
    chk("wrap_tail_pc", deq_pc_o, 32'h3000);
    step();
    deq_ready_i = 0;
    chk("wrap_empty", count_o, 0);

    // Flush priority
    set_lanes(32'h4000, 32'h0);
    inst_mask_i = 8'hFF; iq_enqueue_i = 1;
    step();
    inst_mask_i = 8'h03;
    step();
    chk("flush_pre_count", count_o, 10);
    inst_mask_i = 8'hFF; iq_flush_i = 1; deq_ready_i = 1;
    step();
    iq_flush_i = 0; iq_enqueue_i = 0; deq_ready_i = 0;
    chk("flush_count", count_o, 0);
    chk("flush_valid", deq_valid_o, 0);
    chk("flush_stall", if_stall_o, 0);
    chk("flush_pc", deq_pc_o, 0);
    set_lanes(32'h5000, 32'h0);
    inst_mask_i = 8'h01; iq_enqueue_i = 1;
    step();
    iq_enqueue_i = 0;
    chk("post_flush_pc", deq_pc_o, 32'h5000);
    chk("post_flush_count", count_o, 1);
    deq_ready_i = 1;
    step();
    deq_ready_i = 0;
    chk("post_flush_empty", count_o, 0);

    // Reset mid-burst
    set_lanes(32'h6000, 32'h0);
    inst_mask_i = 8'h1F; iq_enqueue_i = 1;
    step();
    chk("rst_pre_count", count_o, 5);
    inst_mask_i = 8'hFF; rst = 1;
    step();
    rst = 0; iq_enqueue_i = 0;
    chk("rst_mid_count", count_o, 0);
    chk("rst_mid_valid", deq_valid_o, 0);
`ifdef IQ_PERF_CNT_EN
    chk("rst_mid_perf_stall", perf_stall_cycles_o, 0);
    chk("rst_mid_perf_empty", perf_empty_cycles_o, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instr_queue.md
Name: instr_queue

Overview:
- Instruction queue between the fetch stage and decode/dispatch.
- Each cycle, accepts up to 8 fetched entries (PC, instruction word, 2-bit branch prediction) selected by an 8-bit lane mask.
- Compacts the accepted entries in lane order into a circular buffer and presents them to decode one per cycle through a valid/ready handshake.
- Generates the fetch stall and honours a pipeline flush.

Parameters:
- DEPTH, 32, number of entries; power of two, and 16 or more.
- PTR_W, $clog2(DEPTH), width of the head and tail pointers.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- iq_enqueue_i  input  1  fetch block valid this cycle
- inst_mask_i  input  8  lane valid mask; bit i qualifies lane i
- enq_pc_i  input  8x32  PC per lane
- enq_ir_i  input  8x32  instruction word per lane
- enq_br_pred_i  input  8x2  predicted branch counter per lane
- iq_flush_i  input  1  discard all contents (mispredict/redirect)
- if_stall_o  output  1  queue cannot guarantee room for 8 entries
- deq_valid_o  output  1  head entry valid
- deq_ready_i  input  1  decode accepts head entry
- deq_pc_o  output  32  head PC
- deq_ir_o  output  32  head instruction
- deq_br_pred_o  output  2  head prediction
- count_o  output  PTR_W+1  current occupancy

Behaviour:
- Reset (rst=1 at a clk edge):
  - head=0, tail=0, count=0.
  - Outputs: deq_valid_o=0, if_stall_o=0, count_o=0.
  - Data/pc/br_pred outputs are 0 (storage need not be cleared).
  - Reset mid-operation discards all contents; any enqueue or dequeue in that cycle is ignored.
- Stall:
  - if_stall_o = (count > DEPTH-8).
  - Computed from registered count only; no combinational path from any input.
- Enqueue fire:
  - enq_fire = iq_enqueue_i & ~if_stall_o & ~iq_flush_i.
  - On fire, n = popcount(inst_mask_i) entries are written.
  - Set lanes are written at tail, tail+1, ... in ascending lane order; cleared lanes are skipped (compaction).
  - tail advances by n modulo DEPTH.
  - Mask 0 with iq_enqueue_i=1 is legal and is a no-op.
  - iq_enqueue_i=1 while if_stall_o=1 is ignored; fetch is responsible for holding.
- Dequeue:
  - deq_valid_o = (count != 0).
  - deq_*_o are driven combinationally from storage[head].
  - deq_fire = deq_valid_o & deq_ready_i & ~iq_flush_i; on fire, head advances by 1 modulo DEPTH.
- Count:
  - count_next = count + (enq_fire ? n : 0) - (deq_fire ? 1 : 0).
  - Never exceeds DEPTH, by construction of the stall threshold.
- Latency: an enqueued entry is visible at deq_*_o in the cycle after the write; there is no same-cycle bypass.
- Simultaneous events:
  - Enqueue and dequeue in the same cycle: both take effect.
  - Dequeue does not lower if_stall_o within the same cycle.
  - Enqueue into an empty queue with deq_ready_i=1: no dequeue that cycle.
- Flush:
  - iq_flush_i=1 sets head=tail=0 and count=0 at the next edge.
  - Overrides enqueue and dequeue in the same cycle.
  - deq_valid_o=0 and if_stall_o=0 in the following cycle.
- Wrap-around: pointer arithmetic wraps modulo DEPTH; a compacted burst may span the wrap point.

Optional Feature:
- Macro: IQ_PERF_CNT_EN.
- When defined, the block adds two output ports, reset to 0 and flush-insensitive:
  - perf_stall_cycles_o (32 bits): increments every cycle with if_stall_o=1.
  - perf_empty_cycles_o (32 bits): increments every cycle with count=0.
- Both counters saturate at 32'hFFFFFFFF.
- When undefined, neither port nor counter exists, and the block otherwise behaves identically.

Test Plan:
- Mask/compaction:
  - Stimulus: reset; enqueue mask 8'b11111100 with lanes 2..7 at PC 0xaaaaa008..0xaaaaa01c; deq_ready_i=1.
  - Response: count=6 the next cycle; 6 consecutive dequeues output PCs 0xaaaaa008, 0xaaaaa00c, ... 0xaaaaa01c in order; deq_valid_o=0 afterwards.
- Compaction with gaps:
  - Stimulus: mask 8'b10100101 with IR = lane index.
  - Response: dequeued IRs 0, 2, 5, 7; count steps 4, 3, 2, 1, 0.
- Stall threshold (DEPTH=32):
  - Stimulus: three full-mask enqueues with deq_ready_i=0.
  - Response: count=24 and if_stall_o=0. After a fourth enqueue, count=32 and if_stall_o=1. A further enqueue is ignored (count stays 32). After 8 dequeues, if_stall_o=0.
- Wrap-around:
  - Stimulus: preload to head=tail=28 by enqueue/drain; enqueue 8 entries.
  - Response: entries occupy slots 28..31 and 0..3; dequeue order is preserved; tail=4.
- Flush priority:
  - Stimulus: count=10; assert iq_flush_i together with iq_enqueue_i (mask 0xFF) and deq_ready_i=1.
  - Response: the next cycle has count=0, deq_valid_o=0, if_stall_o=0, and no entry from the flush cycle is present.
- Reset mid-burst:
  - Stimulus: rst=1 in the same cycle as an enqueue of 8 entries at count=5.
  - Response: count=0 and deq_valid_o=0 the next cycle; if IQ_PERF_CNT_EN is defined, both counters read 0.
